// File: rtl/counter.sv
// counter: WIDTH-bit free-running up-counter with a count enable.
// Synchronous active-high reset clears the count. Counting wraps modulo 2**WIDTH.
// out comes straight from the state register, so no input reaches it combinationally.
module counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             count,
   output logic [WIDTH-1:0] out
);

   // Count register: reset has priority, then increment, otherwise hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         out <= '0;
      end else if (count) begin
         out <= out + 1'b1;
      end
   end

`ifdef ASSERT_ON
   logic past_vld;

   // Becomes set after the first edge, so $past never looks at pre-simulation history.
   always_ff @(posedge clk) begin
      past_vld <= 1'b1;
   end

   a_reset_clears : assert property (@(posedge clk)
      past_vld && reset |=> out == '0);

   a_count_incr : assert property (@(posedge clk)
      past_vld && count && !reset |=> out == WIDTH'($past(out) + 1'b1));

   a_hold : assert property (@(posedge clk)
      past_vld && !count && !reset |=> out == $past(out));
`endif

endmodule

// File: tb/tb_counter.sv
// tb_counter: directed vectors plus hand-written multi-cycle sequences for counter.
module tb_counter;

   localparam int WIDTH = 4;

   logic             clk;
   logic             reset;
   logic             count;
   logic [WIDTH-1:0] out;

   int checks;
   int failures;

   typedef struct packed {
      logic             reset;
      logic             count;
      logic [WIDTH-1:0] exp;
   } vec_t;

   vec_t vecs [10];

   counter #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .count (count),
      .out   (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one set of inputs across a rising edge, then compare out 1 time unit later.
   task automatic step(input logic r, input logic c, input logic [WIDTH-1:0] exp,
                       input string name);
      reset = r;
      count = c;
      @(posedge clk);
      #1;
      checks++;
      if (out !== exp) begin
         failures++;
         $display("FAIL %s: out=%0d expected=%0d", name, out, exp);
      end
   endtask

   // Safety bound on total run time.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      count    = 1'b0;

      // Reset held two edges with count high, then five counting edges, then hold.
      vecs[0] = '{reset: 1'b1, count: 1'b1, exp: 4'd0};
      vecs[1] = '{reset: 1'b1, count: 1'b1, exp: 4'd0};
      vecs[2] = '{reset: 1'b0, count: 1'b1, exp: 4'd1};
      vecs[3] = '{reset: 1'b0, count: 1'b1, exp: 4'd2};
      vecs[4] = '{reset: 1'b0, count: 1'b1, exp: 4'd3};
      vecs[5] = '{reset: 1'b0, count: 1'b1, exp: 4'd4};
      vecs[6] = '{reset: 1'b0, count: 1'b1, exp: 4'd5};
      vecs[7] = '{reset: 1'b0, count: 1'b0, exp: 4'd5};
      vecs[8] = '{reset: 1'b0, count: 1'b0, exp: 4'd5};
      vecs[9] = '{reset: 1'b1, count: 1'b0, exp: 4'd0};

      for (int i = 0; i < 10; i++) begin
         step(vecs[i].reset, vecs[i].count, vecs[i].exp, $sformatf("vec%0d", i));
      end

      // Wrap: 16 edges from 0 give 1..15 then 0; the 17th gives 1.
      for (int i = 1; i <= 16; i++) begin
         step(1'b0, 1'b1, 4'(i), $sformatf("wrap_edge%0d", i));
      end
      step(1'b0, 1'b1, 4'd1, "wrap_edge17");

      // Hold at 7: clear, count up to 7, hold three edges, then resume to 8.
      step(1'b1, 1'b0, 4'd0, "hold_clear");
      for (int i = 1; i <= 7; i++) begin
         step(1'b0, 1'b1, 4'(i), $sformatf("hold_up%0d", i));
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 4'd7, $sformatf("hold_keep%0d", i));
      end
      step(1'b0, 1'b1, 4'd8, "hold_resume");

      // Reset mid-count: reach 9, one-edge reset pulse with count high, then 1.
      step(1'b0, 1'b1, 4'd9, "mid_reach9");
      step(1'b1, 1'b1, 4'd0, "mid_reset");
      step(1'b0, 1'b1, 4'd1, "mid_restart");

      // Simultaneous reset with count low at 12, then two holding edges at 0.
      for (int i = 2; i <= 12; i++) begin
         step(1'b0, 1'b1, 4'(i), $sformatf("sim_up%0d", i));
      end
      step(1'b1, 1'b0, 4'd0, "sim_reset");
      step(1'b0, 1'b0, 4'd0, "sim_hold0");
      step(1'b0, 1'b0, 4'd0, "sim_hold1");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
